// File: rtl/rxfifo_ctrl_pkg.sv
// Shared definitions for the receive FIFO controller: pop FSM states,
// receive trigger thresholds and the character-timeout limit.
package rxfifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        LOAD = 2'd2
    } popState_e;

    // Character times of silence before the timeout interrupt fires
    localparam int unsigned TIMEOUT_LIMIT = 4;

    function automatic int unsigned trigThreshold(input logic [1:0] lvl);
        case (lvl)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 14;
        endcase
    endfunction

endpackage

// File: rtl/rxfifo_timeout.sv
// Character-timeout counter for the receive path; instantiated by rxfifo_ctrl
// only when RXFIFO_CTRL_TIMEOUT_EN is defined.
module rxfifo_timeout
    import rxfifo_ctrl_pkg::*;
(
    input  logic Clock,
    input  logic Reset,
    input  logic tick_i,
    input  logic active_i,
    input  logic clear_i,
    input  logic intClear_i,
    output logic int_o
);

    localparam logic [1:0] CNT_LAST = 2'(TIMEOUT_LIMIT - 1);

    logic [1:0] cnt_q;
    logic       int_q;

    // The counter parks at its last value once the interrupt is raised
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            int_q <= 1'b0;
        end else begin
            if (intClear_i) begin
                int_q <= 1'b0;
            end
            if (clear_i || !active_i) begin
                cnt_q <= '0;
            end else if (tick_i) begin
                if (cnt_q == CNT_LAST) begin
                    int_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 2'd1;
                end
            end
        end
    end

    assign int_o = int_q;

endmodule

// File: rtl/rxfifo_ctrl.sv
// UART receive-side controller: feeds the external FIFO, pops it into the holding
// register and tracks occupancy, errors and overrun. Optional timeout: RXFIFO_CTRL_TIMEOUT_EN.
module rxfifo_ctrl
    import rxfifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [2:0]  rx_err,
    input  logic        fifo_en,
    input  logic [1:0]  trig_lvl,
    input  logic        char_tick,
    input  logic        rd_rbr,
    input  logic        rd_lsr,
    input  logic        flush,
    output logic [10:0] fifo_wdata,
    output logic        fifo_wren,
    output logic        fifo_rden,
    output logic        fifo_rst,
    input  logic [7:0]  fifo_q,
    input  logic [2:0]  fifo_qerr,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    output logic [7:0]  rbr,
    output logic [2:0]  rbr_err,
    output logic        data_ready,
    output logic        overrun,
    output logic        err_pending,
    output logic        int_rx,
    output logic        int_to
);

    localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(DEPTH + 1);

    popState_e        state_q;
    logic [7:0]       rbr_q;
    logic [2:0]       rbrErr_q;
    logic             dataReady_q;
    logic             overrun_q;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    logic wrFifo, directLoad, rdAccept, overrunEvt, errAdd, errLeave;

    // A character arriving together with flush is discarded with the rest
    assign wrFifo     = fifo_en && rx_valid && !fifo_full && !flush;
    assign directLoad = !fifo_en && rx_valid && !flush;
    assign rdAccept   = rd_rbr && dataReady_q;
    assign overrunEvt = rx_valid && (fifo_en ? fifo_full : (dataReady_q && !rd_rbr));
    assign errAdd     = (wrFifo || directLoad) && (rx_err != 3'b000);
    assign errLeave   = dataReady_q && (rbrErr_q != 3'b000) && (rd_rbr || directLoad);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            rbr_q       <= '0;
            rbrErr_q    <= '0;
            dataReady_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            dataReady_q <= 1'b0;
        end else begin
            if (rdAccept) begin
                dataReady_q <= 1'b0;
            end
            if (directLoad) begin
                rbr_q       <= rx_data;
                rbrErr_q    <= rx_err;
                dataReady_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fifo_en && !dataReady_q && !fifo_empty) begin
                        state_q <= POP;
                    end
                end
                POP: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    rbr_q       <= fifo_q;
                    rbrErr_q    <= fifo_qerr;
                    dataReady_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Occupancy includes the holding register; moving FIFO->rbr leaves it unchanged
    always_comb begin
        occ_d = occ_q;
        if (!fifo_en) begin
            occ_d = (directLoad || (dataReady_q && !rd_rbr)) ? CNT_W'(1) : '0;
        end else if (wrFifo && !rdAccept && occ_q != OCC_MAX) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (!wrFifo && rdAccept && occ_q != '0) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_comb begin
        errCnt_d = errCnt_q;
        if (errAdd && !errLeave && errCnt_q != OCC_MAX) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end else if (!errAdd && errLeave && errCnt_q != '0) begin
            errCnt_d = errCnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            occ_q     <= '0;
            errCnt_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (overrunEvt) begin
                overrun_q <= 1'b1;
            end else if (rd_lsr) begin
                overrun_q <= 1'b0;
            end
            if (flush) begin
                occ_q    <= '0;
                errCnt_q <= '0;
            end else begin
                occ_q    <= occ_d;
                errCnt_q <= errCnt_d;
            end
        end
    end

`ifdef RXFIFO_CTRL_TIMEOUT_EN
    rxfifo_timeout u_timeout (
        .Clock      (Clock),
        .Reset      (Reset),
        .tick_i     (char_tick),
        .active_i   (fifo_en && (occ_q != '0)),
        .clear_i    (rx_valid || rd_rbr || flush),
        .intClear_i (rd_rbr || flush),
        .int_o      (int_to)
    );
`else
    logic unusedTick;
    assign unusedTick = char_tick;
    assign int_to     = 1'b0;
`endif

    assign fifo_wdata  = {rx_data, rx_err};
    assign fifo_wren   = wrFifo;
    assign fifo_rden   = (state_q == POP) && !flush;
    assign fifo_rst    = flush;
    assign rbr         = rbr_q;
    assign rbr_err     = rbrErr_q;
    assign data_ready  = dataReady_q;
    assign overrun     = overrun_q;
    assign err_pending = (errCnt_q != '0);
    assign int_rx      = fifo_en ? (occ_q >= CNT_W'(trigThreshold(trig_lvl))) : dataReady_q;

endmodule

// File: tb/tb_rxfifo_ctrl.sv
// Scoreboard bench for rxfifo_ctrl with a behavioural 16-entry FIFO attached;
// define RXFIFO_CTRL_TIMEOUT_EN to expect the timeout interrupt.
module tb_rxfifo_ctrl;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

`ifdef RXFIFO_CTRL_TIMEOUT_EN
    localparam logic TO_EXPECTED = 1'b1;
`else
    localparam logic TO_EXPECTED = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [2:0]  rx_err = '0;
    logic        fifo_en = 1'b1;
    logic [1:0]  trig_lvl = 2'b00;
    logic        char_tick = 1'b0;
    logic        rd_rbr = 1'b0;
    logic        rd_lsr = 1'b0;
    logic        flush = 1'b0;
    logic [10:0] fifo_wdata;
    logic        fifo_wren, fifo_rden, fifo_rst;
    logic [7:0]  fifo_q = '0;
    logic [2:0]  fifo_qerr = '0;
    logic        fifo_empty, fifo_full;
    logic [7:0]  rbr;
    logic [2:0]  rbr_err;
    logic        data_ready, overrun, err_pending, int_rx, int_to;

    int checks = 0;
    int errors = 0;

    logic [10:0] expQ[$];
    logic [10:0] fifoMem[$];
    int          fifoCount = 0;
    logic [10:0] sbExp;
    logic        prevDr = 1'b0;

    rxfifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .fifo_en(fifo_en), .trig_lvl(trig_lvl), .char_tick(char_tick),
        .rd_rbr(rd_rbr), .rd_lsr(rd_lsr), .flush(flush), .fifo_wdata(fifo_wdata),
        .fifo_wren(fifo_wren), .fifo_rden(fifo_rden), .fifo_rst(fifo_rst),
        .fifo_q(fifo_q), .fifo_qerr(fifo_qerr), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .rbr(rbr), .rbr_err(rbr_err), .data_ready(data_ready),
        .overrun(overrun), .err_pending(err_pending), .int_rx(int_rx), .int_to(int_to)
    );

    always #5 Clock = ~Clock;

    // Behavioural receive FIFO: read data appears the cycle after fifo_rden
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            fifoMem.delete();
            fifo_q    <= '0;
            fifo_qerr <= '0;
        end else if (fifo_rst) begin
            fifoMem.delete();
        end else begin
            if (fifo_rden && fifoMem.size() > 0) begin
                fifo_q    <= fifoMem[0][10:3];
                fifo_qerr <= fifoMem[0][2:0];
                void'(fifoMem.pop_front());
            end
            if (fifo_wren && fifoMem.size() < DEPTH) begin
                fifoMem.push_back(fifo_wdata);
            end
        end
        fifoCount <= fifoMem.size();
    end

    assign fifo_empty = (fifoCount == 0);
    assign fifo_full  = (fifoCount >= DEPTH);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Every new character presented in the holding register is matched against the queue
    always @(negedge Clock) begin
        if (data_ready && !prevDr) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got rbr=%0h err=%0h expected no character", rbr, rbr_err);
            end else begin
                sbExp = expQ.pop_front();
                checkOutput("sb_rbr", 32'(rbr), 32'(sbExp[10:3]));
                checkOutput("sb_rbr_err", 32'(rbr_err), 32'(sbExp[2:0]));
            end
        end
        prevDr = data_ready;
    end

    task automatic applyStimulus(input logic rxv, input logic [7:0] d, input logic [2:0] e,
                                 input logic rdR, input logic rdL, input logic fl, input logic tk);
        rx_valid  = rxv;
        rx_data   = d;
        rx_err    = e;
        rd_rbr    = rdR;
        rd_lsr    = rdL;
        flush     = fl;
        char_tick = tk;
        @(negedge Clock);
        rx_valid  = 1'b0;
        rd_rbr    = 1'b0;
        rd_lsr    = 1'b0;
        flush     = 1'b0;
        char_tick = 1'b0;
    endtask

    task automatic writeChar(input logic [7:0] d, input logic [2:0] e, input logic expectOut);
        if (expectOut) expQ.push_back({d, e});
        applyStimulus(1'b1, d, e, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic readRbr();
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (!data_ready && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (!data_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: data_ready got 0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic drain(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            waitReady(name);
            readRbr();
            checkOutput({name, "_rd_clears_dr"}, 32'(data_ready), 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge Clock);
        checkOutput("rst_data_ready", 32'(data_ready), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_rbr", 32'({rbr, rbr_err}), 0);
        checkOutput("rst_flags", 32'({err_pending, int_rx, int_to}), 0);
        checkOutput("rst_fifo_ctl", 32'({fifo_rst, fifo_wren, fifo_rden}), 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Reset landing in the middle of a pop
        writeChar(8'h99, 3'b000, 1'b0);
        @(negedge Clock);
        checkOutput("pop_in_flight", 32'(fifo_rden), 1);
        #2 Reset = 1'b1;
        #1 checkOutput("rst_kills_rden", 32'(fifo_rden), 0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checkOutput("no_rden_after_rst", 32'(fifo_rden), 0);
        end
        checkOutput("no_load_after_rst", 32'(data_ready), 0);

        // Three characters through the FIFO into the holding register
        expQ.push_back({8'h41, 3'b000});
        rx_valid = 1'b1; rx_data = 8'h41; rx_err = 3'b000;
        #1 checkOutput("wren_same_cycle", 32'(fifo_wren), 1);
        checkOutput("wdata", 32'(fifo_wdata), 32'({8'h41, 3'b000}));
        @(negedge Clock);
        rx_valid = 1'b0;
        writeChar(8'h42, 3'b000, 1'b1);
        writeChar(8'h43, 3'b000, 1'b1);
        checkOutput("dr_not_yet", 32'(data_ready), 0);
        @(negedge Clock);
        checkOutput("dr_3_cycles", 32'(data_ready), 1);
        checkOutput("rbr_first", 32'(rbr), 32'h41);
        checkOutput("int_rx_lvl1", 32'(int_rx), 1);
        drain(3, "three_chars");
        repeat (4) @(negedge Clock);
        checkOutput("empty_no_dr", 32'(data_ready), 0);
        checkOutput("empty_int_rx", 32'(int_rx), 0);

        // Trigger level 4, plus simultaneous write and read
        trig_lvl = 2'b01;
        writeChar(8'h61, 3'b000, 1'b1);
        writeChar(8'h62, 3'b000, 1'b1);
        writeChar(8'h63, 3'b000, 1'b1);
        checkOutput("int_rx_occ3", 32'(int_rx), 0);
        writeChar(8'h64, 3'b000, 1'b1);
        checkOutput("int_rx_occ4", 32'(int_rx), 1);
        expQ.push_back({8'h65, 3'b000});
        applyStimulus(1'b1, 8'h65, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("wr_rd_same_cycle", 32'(int_rx), 1);
        waitReady("trig4");
        readRbr();
        checkOutput("int_rx_occ3_after_rd", 32'(int_rx), 0);
        drain(3, "trig4");

        // Error tracking
        trig_lvl = 2'b00;
        writeChar(8'h55, 3'b010, 1'b1);
        checkOutput("err_pending_set", 32'(err_pending), 1);
        drain(1, "err_char");
        checkOutput("err_pending_clr", 32'(err_pending), 0);

        // Fill past capacity with one character already held
        trig_lvl = 2'b11;
        writeChar(8'hA0, 3'b000, 1'b1);
        waitReady("preload");
        for (int i = 0; i < 17; i++) begin
            writeChar(8'hB0 + 8'(i), 3'b000, i < 16);
            if (i == 11) checkOutput("int_rx_occ13", 32'(int_rx), 0);
            if (i == 12) checkOutput("int_rx_occ14", 32'(int_rx), 1);
            if (i == 15) checkOutput("no_overrun_at_full", 32'(overrun), 0);
            if (i == 16) checkOutput("overrun_17th", 32'(overrun), 1);
        end
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lsr_clears_overrun", 32'(overrun), 0);
        applyStimulus(1'b1, 8'hEE, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("overrun_beats_lsr", 32'(overrun), 1);
        drain(17, "full_drain");
        repeat (5) @(negedge Clock);
        checkOutput("lost_char_absent", 32'(data_ready), 0);

        // Flush while a pop is in flight
        trig_lvl = 2'b00;
        writeChar(8'h77, 3'b001, 1'b0);
        @(negedge Clock);
        checkOutput("flush_pop_in_flight", 32'(fifo_rden), 1);
        flush = 1'b1;
        #1 checkOutput("fifo_rst_on", 32'(fifo_rst), 1);
        checkOutput("flush_abandons_rden", 32'(fifo_rden), 0);
        @(negedge Clock);
        flush = 1'b0;
        checkOutput("fifo_rst_one_cycle", 32'(fifo_rst), 0);
        checkOutput("flush_dr", 32'(data_ready), 0);
        checkOutput("flush_keeps_overrun", 32'(overrun), 1);
        repeat (4) @(negedge Clock);
        checkOutput("flush_idle", 32'({data_ready, fifo_rden}), 0);
        checkOutput("flush_occ_err", 32'({int_rx, err_pending}), 0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("overrun_cleared", 32'(overrun), 0);

        // Stray read while nothing is held, then character timeout
        writeChar(8'h31, 3'b000, 1'b1);
        readRbr();
        checkOutput("stray_rd_keeps_occ", 32'(int_rx), 1);
        waitReady("timeout_char");
        for (int i = 0; i < 4; i++) begin
            if (i == 3) checkOutput("int_to_after_3", 32'(int_to), 0);
            applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge Clock);
        end
        checkOutput("int_to_after_4", 32'(int_to), 32'(TO_EXPECTED));
        readRbr();
        checkOutput("int_to_cleared", 32'(int_to), 0);

        // Single holding-register mode
        fifo_en = 1'b0;
        expQ.push_back({8'h11, 3'b000});
        rx_valid = 1'b1; rx_data = 8'h11; rx_err = 3'b000;
        #1 checkOutput("nofifo_no_wren", 32'(fifo_wren), 0);
        @(negedge Clock);
        rx_valid = 1'b0;
        checkOutput("nofifo_int_rx", 32'(int_rx), 1);
        writeChar(8'h22, 3'b001, 1'b0);
        checkOutput("nofifo_overwrite", 32'({rbr, rbr_err}), 32'({8'h22, 3'b001}));
        checkOutput("nofifo_overrun", 32'(overrun), 1);
        checkOutput("nofifo_err_pending", 32'(err_pending), 1);
        readRbr();
        checkOutput("nofifo_after_rd", 32'({data_ready, err_pending, int_rx}), 0);
        applyStimulus(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("nofifo_overrun_clr", 32'(overrun), 0);
        fifo_en = 1'b1;

        repeat (3) @(negedge Clock);
        checkOutput("sb_drained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit expected run to finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
